// File: rtl/lpc_pkg.sv
// lpc_pkg: shared types and defaults for the LPC synthesis filter.
// State encoding, sample/coefficient types and size constants.
package lpc_pkg;
  localparam int ORDER_MAX  = 12;
  localparam int COEF_W     = 15;
  localparam int RESID_W    = 24;
  localparam int ACC_W      = 40;
  localparam int BLOCK_SIZE = 4096;

  typedef enum logic [2:0] {
    IDLE, LOAD, ACCEPT, MAC, SUM, EMIT
  } state_t;

  typedef logic signed [15:0]       sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;
endpackage

// File: rtl/lpc_mac.sv
// lpc_mac: one signed multiply-accumulate per cycle.
// Clear has priority over enable; product is sign-extended into acc.
module lpc_mac import lpc_pkg::*; #(
  parameter int A_W = COEF_W,
  parameter int B_W = 16,
  parameter int AW  = ACC_W
) (
  input  logic                 iClock,
  input  logic                 iReset_n,
  input  logic                 iClear,
  input  logic                 iEnable,
  input  logic signed [A_W-1:0] iA,
  input  logic signed [B_W-1:0] iB,
  output logic signed [AW-1:0]  oAcc
);
  localparam int P_W = A_W + B_W;

  logic signed [P_W-1:0] prod;

  assign prod = iA * iB;

  // accumulate the current product, or restart from zero
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      oAcc <= '0;
    end else if (iClear) begin
      oAcc <= '0;
    end else if (iEnable) begin
      oAcc <= oAcc + {{(AW-P_W){prod[P_W-1]}}, prod};
    end
  end
endmodule

// File: rtl/lpc_synthesis.sv
// lpc_synthesis: decoder-side LPC synthesis, rebuilds PCM from residuals.
// Optional LPC_SYNTHESIS_SATURATE_EN clamps results and adds sticky oClip.
module lpc_synthesis #(
  parameter int ORDER_MAX  = lpc_pkg::ORDER_MAX,
  parameter int COEF_W     = lpc_pkg::COEF_W,
  parameter int RESID_W    = lpc_pkg::RESID_W,
  parameter int ACC_W      = lpc_pkg::ACC_W,
  parameter int BLOCK_SIZE = lpc_pkg::BLOCK_SIZE
) (
  input  logic                      iClock,
  input  logic                      iReset_n,
  input  logic                      iStart,
  input  logic [3:0]                iOrder,
  input  logic [4:0]                iShift,
  input  logic                      iCoeffValid,
  input  logic signed [COEF_W-1:0]  iCoeff,
  input  logic signed [RESID_W-1:0] iResidual,
  input  logic                      iValid,
  output logic                      oReady,
  output logic signed [15:0]        oSample,
  output logic                      oValid,
  output logic                      oBlockDone,
`ifdef LPC_SYNTHESIS_SATURATE_EN
  output logic                      oClip,
`endif
  output logic                      oBusy
);
  import lpc_pkg::*;

  localparam int NW = $clog2(BLOCK_SIZE);
  localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] S_MIN = ACC_W'(-32768);

  state_t state, state_n;

  logic [3:0]               order_q;
  logic [4:0]               shift_q;
  logic [3:0]               k_q;
  logic [3:0]               j_q;
  logic [NW-1:0]            n_q;
  logic signed [COEF_W-1:0] coef_q [ORDER_MAX];
  sample_t                  hist_q [ORDER_MAX];
  logic signed [RESID_W-1:0] resid_q;
  sample_t                  sample_q;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  pre;
  sample_t                  narrowed;
  logic [3:0]               ord_in;
  logic [3:0]               ord_m1;
  logic                     take;
  logic                     direct;
  logic                     last;
`ifdef LPC_SYNTHESIS_SATURATE_EN
  logic                     clip_d;
  logic                     clip_q;
  assign oClip = clip_q;
`endif

  function automatic logic signed [ACC_W-1:0] sext(
    input logic signed [RESID_W-1:0] v
  );
    return $signed({{(ACC_W-RESID_W){v[RESID_W-1]}}, v});
  endfunction

  assign ord_in  = (iOrder > 4'(ORDER_MAX)) ? 4'(ORDER_MAX) : iOrder;
  assign ord_m1  = order_q - 4'd1;
  assign take    = (state == ACCEPT) && iValid;
  assign direct  = (order_q == 4'd0) || (n_q < NW'(order_q));
  assign last    = n_q == NW'(BLOCK_SIZE - 1);
  assign oSample = sample_q;

  lpc_mac #(
    .A_W (COEF_W),
    .B_W (16),
    .AW  (ACC_W)
  ) u_mac (
    .iClock   (iClock),
    .iReset_n (iReset_n),
    .iClear   (take && !direct),
    .iEnable  (state == MAC),
    .iA       (coef_q[j_q]),
    .iB       (hist_q[j_q]),
    .oAcc     (acc)
  );

  // pre-narrowing result: verbatim beat, or residual plus floored prediction
  always_comb begin
    pre = sext(iResidual);
    if (state == SUM) begin
      pre = sext(resid_q) + (acc >>> shift_q);
    end
  end

  // narrow to 16 bits: wrap by default, clamp when saturation is built in
  always_comb begin
    narrowed = pre[15:0];
`ifdef LPC_SYNTHESIS_SATURATE_EN
    clip_d = 1'b0;
    if (pre > S_MAX) begin
      narrowed = 16'sh7fff;
      clip_d   = 1'b1;
    end else if (pre < S_MIN) begin
      narrowed = 16'sh8000;
      clip_d   = 1'b1;
    end
`endif
  end

  // state register
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) state <= IDLE;
    else           state <= state_n;
  end

  // next state and handshake outputs
  always_comb begin
    state_n    = state;
    oReady     = 1'b0;
    oValid     = 1'b0;
    oBlockDone = 1'b0;
    oBusy      = state != IDLE;
    unique case (state)
      IDLE: begin
        if (iStart) state_n = (ord_in == 4'd0) ? ACCEPT : LOAD;
      end
      LOAD: begin
        if (iCoeffValid && k_q == ord_m1) state_n = ACCEPT;
      end
      ACCEPT: begin
        oReady = 1'b1;
        if (iValid) state_n = direct ? EMIT : MAC;
      end
      MAC: begin
        if (j_q == ord_m1) state_n = SUM;
      end
      SUM: state_n = EMIT;
      EMIT: begin
        oValid = 1'b1;
        if (last) begin
          oBlockDone = 1'b1;
          state_n    = IDLE;
        end else begin
          state_n = ACCEPT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // datapath: block setup, coefficient load, sample capture, history shift
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      order_q  <= '0;
      shift_q  <= '0;
      k_q      <= '0;
      j_q      <= '0;
      n_q      <= '0;
      resid_q  <= '0;
      sample_q <= '0;
      for (int i = 0; i < ORDER_MAX; i++) begin
        coef_q[i] <= '0;
        hist_q[i] <= '0;
      end
`ifdef LPC_SYNTHESIS_SATURATE_EN
      clip_q <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (iStart) begin
            order_q <= ord_in;
            shift_q <= iShift;
            k_q     <= '0;
            n_q     <= '0;
            for (int i = 0; i < ORDER_MAX; i++) begin
              coef_q[i] <= '0;
              hist_q[i] <= '0;
            end
`ifdef LPC_SYNTHESIS_SATURATE_EN
            clip_q <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (iCoeffValid) begin
            coef_q[k_q] <= iCoeff;
            k_q         <= k_q + 4'd1;
          end
        end
        ACCEPT: begin
          if (iValid) begin
            resid_q <= iResidual;
            j_q     <= '0;
            if (direct) begin
              sample_q <= narrowed;
`ifdef LPC_SYNTHESIS_SATURATE_EN
              clip_q <= clip_q | clip_d;
`endif
            end
          end
        end
        MAC: j_q <= j_q + 4'd1;
        SUM: begin
          sample_q <= narrowed;
`ifdef LPC_SYNTHESIS_SATURATE_EN
          clip_q <= clip_q | clip_d;
`endif
        end
        EMIT: begin
          hist_q[0] <= sample_q;
          for (int i = ORDER_MAX - 1; i > 0; i--) begin
            hist_q[i] <= hist_q[i-1];
          end
          n_q <= n_q + NW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lpc_synthesis.sv
// tb_lpc_synthesis: table vectors plus scoreboard for lpc_synthesis.
// Expected samples, latencies and done flags are queued at each beat.
module tb_lpc_synthesis;
  logic               iClock;
  logic               iReset_n;
  logic               iStart;
  logic [3:0]         iOrder;
  logic [4:0]         iShift;
  logic               iCoeffValid;
  logic signed [14:0] iCoeff;
  logic signed [23:0] iResidual;
  logic               iValid;
  logic               oReady;
  logic signed [15:0] oSample;
  logic               oValid;
  logic               oBlockDone;
  logic               oBusy;
`ifdef LPC_SYNTHESIS_SATURATE_EN
  logic               oClip;
`endif

  lpc_synthesis dut (
    .iClock      (iClock),
    .iReset_n    (iReset_n),
    .iStart      (iStart),
    .iOrder      (iOrder),
    .iShift      (iShift),
    .iCoeffValid (iCoeffValid),
    .iCoeff      (iCoeff),
    .iResidual   (iResidual),
    .iValid      (iValid),
    .oReady      (oReady),
    .oSample     (oSample),
    .oValid      (oValid),
    .oBlockDone  (oBlockDone),
`ifdef LPC_SYNTHESIS_SATURATE_EN
    .oClip       (oClip),
`endif
    .oBusy       (oBusy)
  );

  initial begin
    iClock = 1'b0;
    forever #5 iClock = ~iClock;
  end

  typedef struct packed {
    logic [3:0]        ord;
    logic [4:0]        sh;
    logic [3:0]        nc;
    logic [3:0]        nb;
    logic [11:0][15:0] coef;
    logic [13:0][23:0] res;
    logic [13:0][15:0] exp;
  } vec_t;

  typedef struct packed {
    int   e;
    int   due;
    logic done;
  } sb_t;

  localparam int NV = 7;
  vec_t vecs [NV];
  sb_t  q [$];
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total = 0;

  always @(posedge iClock) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic new_vec(input int v, input int o, input int s);
    vecs[v]     = '0;
    vecs[v].ord = 4'(o);
    vecs[v].sh  = 5'(s);
  endtask

  task automatic add_coef(input int v, input int c);
    vecs[v].coef[vecs[v].nc] = 16'(c);
    vecs[v].nc = vecs[v].nc + 4'd1;
  endtask

  task automatic add_beat(input int v, input int r, input int e);
    vecs[v].res[vecs[v].nb] = 24'(r);
    vecs[v].exp[vecs[v].nb] = 16'(e);
    vecs[v].nb = vecs[v].nb + 4'd1;
  endtask

  // output monitor: pop expected entry on every oValid
  always @(negedge iClock) begin
    if (iReset_n) begin
      if (oBlockDone && !oValid) chk("done_without_valid", 1, 0);
      if (oValid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          sb_t s;
          s = q.pop_front();
          chk("sample", longint'(oSample), longint'(s.e));
          chk("latency", cyc, s.due);
          chk("block_done", longint'(oBlockDone), longint'(s.done));
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge iClock);
    iReset_n    = 1'b0;
    iStart      = 1'b0;
    iValid      = 1'b0;
    iCoeffValid = 1'b0;
    repeat (2) @(negedge iClock);
    q.delete();
    iReset_n = 1'b1;
    @(negedge iClock);
  endtask

  task automatic start_block(input logic [3:0] o, input logic [4:0] s);
    iOrder = o;
    iShift = s;
    iStart = 1'b1;
    @(negedge iClock);
    iStart = 1'b0;
  endtask

  task automatic send_beat(input int r, input int e, input int lat, input logic done);
    int t;
    sb_t s;
    iResidual = 24'(r);
    iValid    = 1'b1;
    t = 0;
    while (!oReady && t < 200) begin
      @(negedge iClock);
      t++;
    end
    if (!oReady) begin
      chk("ready_timeout", 0, 1);
      iValid = 1'b0;
      return;
    end
    s.e    = e;
    s.due  = cyc + lat;
    s.done = done;
    q.push_back(s);
    @(negedge iClock);
    iValid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge iClock);
      t++;
    end
    chk("drain", q.size(), 0);
  endtask

  task automatic run_vec(input int v);
    int eff;
    int lat;
    do_reset();
    start_block(vecs[v].ord, vecs[v].sh);
    for (int k = 0; k < int'(vecs[v].nc); k++) begin
      iCoeffValid = 1'b1;
      iCoeff      = vecs[v].coef[k][14:0];
      @(negedge iClock);
    end
    iCoeffValid = 1'b0;
    eff = (vecs[v].ord > 4'd12) ? 12 : int'(vecs[v].ord);
    for (int i = 0; i < int'(vecs[v].nb); i++) begin
      lat = (eff == 0 || i < eff) ? 1 : eff + 2;
      send_beat(int'($signed(vecs[v].res[i])),
                int'($signed(vecs[v].exp[i])), lat, 1'b0);
    end
    drain();
  endtask

  initial begin
    iReset_n    = 1'b0;
    iStart      = 1'b0;
    iOrder      = '0;
    iShift      = '0;
    iCoeffValid = 1'b0;
    iCoeff      = '0;
    iResidual   = '0;
    iValid      = 1'b0;

    new_vec(0, 1, 0);
    add_coef(0, 1);
    add_beat(0, 100, 100);
    for (int i = 1; i < 5; i++) add_beat(0, 1, 100 + i);

    new_vec(1, 2, 0);
    add_coef(1, 2);
    add_coef(1, -1);
    add_beat(1, 0, 0);
    add_beat(1, 10, 10);
    for (int i = 2; i < 6; i++) add_beat(1, 0, 10 * i);

    new_vec(2, 1, 13);
    add_coef(2, 8192);
    add_beat(2, -7, -7);
    for (int i = 1; i < 4; i++) add_beat(2, 0, -7);

    new_vec(3, 1, 0);
    add_coef(3, 2);
    add_beat(3, 30000, 30000);
`ifdef LPC_SYNTHESIS_SATURATE_EN
    add_beat(3, 0, 32767);
    add_beat(3, 0, 32767);
    add_beat(3, 0, 32767);
`else
    add_beat(3, 0, -5536);
    add_beat(3, 0, -11072);
    add_beat(3, 0, -22144);
`endif

    new_vec(4, 1, 1);
    add_coef(4, 3);
    add_beat(4, -5, -5);
    add_beat(4, 0, -8);
    add_beat(4, 0, -12);
    add_beat(4, 0, -18);
    add_beat(4, 0, -27);

    new_vec(5, 15, 0);
    add_coef(5, 1);
    for (int i = 1; i < 12; i++) add_coef(5, 0);
    for (int i = 1; i <= 12; i++) add_beat(5, i, i);
    add_beat(5, 5, 17);
    add_beat(5, 0, 17);

    new_vec(6, 3, 2);
    add_coef(6, 4);
    add_coef(6, -2);
    add_coef(6, 1);
    add_beat(6, 8, 8);
    add_beat(6, -4, -4);
    add_beat(6, 12, 12);
    add_beat(6, 3, 19);
    add_beat(6, -1, 11);

    repeat (3) @(negedge iClock);
    chk("rst_ready", oReady, 0);
    chk("rst_valid", oValid, 0);
    chk("rst_done", oBlockDone, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_sample", oSample, 0);
    iReset_n = 1'b1;
    @(negedge iClock);

    for (int v = 0; v < NV; v++) begin
      run_vec(v);
`ifdef LPC_SYNTHESIS_SATURATE_EN
      chk("clip", oClip, (v == 3) ? 1 : 0);
`endif
    end

    do_reset();
    start_block(4'd2, 5'd0);
    iCoeffValid = 1'b1;
    iCoeff = 15'sd2;
    @(negedge iClock);
    iCoeff = -15'sd1;
    @(negedge iClock);
    iCoeffValid = 1'b0;
    send_beat(0, 0, 1, 1'b0);
    send_beat(10, 10, 1, 1'b0);
    drain();
    iResidual = '0;
    iValid = 1'b1;
    for (int t = 0; t < 20 && !oReady; t++) @(negedge iClock);
    chk("mac_ready_seen", oReady, 1);
    @(posedge iClock);
    #1;
    chk("mac_busy", oBusy, 1);
    chk("mac_ready_low", oReady, 0);
    iReset_n = 1'b0;
    #1;
    chk("midrst_ready", oReady, 0);
    chk("midrst_valid", oValid, 0);
    chk("midrst_done", oBlockDone, 0);
    chk("midrst_busy", oBusy, 0);
    chk("midrst_sample", oSample, 0);
    iValid = 1'b0;
    q.delete();
    @(negedge iClock);
    iReset_n = 1'b1;
    @(negedge iClock);

    start_block(4'd0, 5'd0);
    for (int i = 0; i < 4096; i++) begin
      if (i == 10) start_block(4'd5, 5'd3);
      send_beat(i, i, 1, i == 4095);
    end
    drain();
    @(negedge iClock);
    chk("busy_after_done", oBusy, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
